cos_sweep_sequencer: RTL and testbench
======================================

// Module: cos_sweep_sequencer
// PURPOSE
//  Synthesizable initiator for the cosine engine's start/ready interface.
//  - Issues a programmed sweep of angles to the engine, one request at a time.
//  - Captures each result and streams (angle, cos) pairs out through a small result FIFO.
//  - Replaces bench-only stimulus so on-board sweeps run without a CPU.
//  - Sits between the register/control logic and the engine.
// PARAMETERS
//  DATA_W         24    fixed-point word width (Q13.10 two's complement, 10 fractional bits)
//  CNT_W          10    width of point_count
//  FIFO_DEPTH     4     result FIFO entries, power of two
//  TIMEOUT_CYCLES 4096  max cycles from eng_start to eng_ready rising edge
// PORTS
//  clock        in   1       single clock domain, rising edge
//  reset        in   1       asynchronous, active-high
//  sweep_start  in   1       pulse; starts a sweep when idle
//  angle_first  in   DATA_W  first angle, sampled on accepted sweep_start
//  angle_step   in   DATA_W  per-point increment, sampled on accepted sweep_start
//  point_count  in   CNT_W   number of points, sampled on accepted sweep_start
//  busy         out  1       high from accepted sweep_start until the done cycle
//  done         out  1       one-cycle pulse at end of sweep (normal or aborted)
//  error        out  1       sticky timeout flag; cleared by next accepted sweep_start
//  eng_start    out  1       one-cycle request pulse to engine
//  eng_angle    out  DATA_W  angle to engine; stable from eng_start until capture
//  eng_ready    in   1       engine completion level; its rising edge marks a result
//  eng_cos      in   DATA_W  engine result; valid one cycle after eng_ready rises
//  res_valid    out  1       result FIFO non-empty
//  res_ready    in   1       consumer accept; pop when res_valid && res_ready
//  res_angle    out  DATA_W  angle of head entry
//  res_cos      out  DATA_W  cos of head entry
// BEHAVIOUR
//  Reset values:
//  - All outputs 0; FIFO empty; state IDLE.
//  - eng_ready edge register cleared to 0.
//  FSM states: IDLE, ISSUE, WAIT, CAPTURE, FINISH.
//  - IDLE: on sweep_start, latch inputs, clear error, set busy.
//    - Go to FINISH if point_count==0, else to ISSUE.
//    - sweep_start while busy is ignored.
//  - ISSUE: when FIFO not full, assert eng_start for 1 cycle with eng_angle = current angle.
//    - Clear timeout counter; go to WAIT.
//    - While FIFO is full, stay in ISSUE with eng_start low.
//  - WAIT: eng_ready rise = (eng_ready && !eng_ready_q) moves to CAPTURE.
//    - Counter reaching TIMEOUT_CYCLES sets error and moves to FINISH, abandoning remaining points.
//    - A level already high at issue does not count; a fresh rise is required.
//  - CAPTURE: push {eng_angle, eng_cos} (space guaranteed by ISSUE).
//    - angle += angle_step, modulo 2^DATA_W (wraps, no saturation).
//    - Decrement remaining; go to ISSUE if nonzero, else FINISH.
//  - FINISH: done=1 for one cycle, busy=0, go to IDLE.
//    - FIFO contents remain and drain normally.
//  Latency: eng_start is 1 cycle after entering ISSUE; FIFO push is 2 cycles after eng_ready rises.
//  FIFO push and pop in the same cycle are both honoured; the count is unchanged.
//  Reset mid-sweep: immediate abort, FIFO flushed, no done pulse.
// STRUCTURE
//  Package taylor_pkg:
//  - DATA_W, FXP_FRAC=10, typedef logic signed [DATA_W-1:0] fxp_t.
//  - typedef struct packed {fxp_t angle; fxp_t cos;} cos_result_t.
//  - seq_state_t enum.
//  Sub-module sweep_result_fifo: synchronous FIFO of cos_result_t with full/empty and same-cycle push/pop.
// TESTING (engine model: eng_ready rises 20 cycles after eng_start, returns round(cos(a)*1024))
//  - Single point: first=1536 (1.5), count=1 -> one eng_start, eng_angle=1536; res (1536,72); done; error=0.
//  - Sweep: first=0, step=256, count=4, res_ready=1 -> res pairs (0,1024) (256,992) (512,899) (768,749), in order.
//  - Backpressure: count=8, res_ready=0 -> exactly 4 eng_start then stall in ISSUE; res_ready=1 -> remaining 4, total 8 results.
//  - Timeout: model never raises eng_ready, TIMEOUT_CYCLES=64 -> error=1, done pulse, busy=0, no res_valid.
//  - Edge cases: count=0 -> done without eng_start; first=0x7FFF00, step=0x000200 -> 2nd angle 0x800100.
//  - Reset asserted mid-WAIT -> all outputs 0 asynchronously; after release, new sweep runs normally.

Source files
------------

// File: rtl/taylor_pkg.sv
// rtl/taylor_pkg.sv - shared fixed-point types and sequencer state encoding
// Purpose: Q13.10 word type, result record and sweep FSM states used by the
//          cosine sweep sequencer, its result FIFO and its bus interface.
package taylor_pkg;

    localparam int DATA_W   = 24;
    localparam int FXP_FRAC = 10;

    typedef logic signed [DATA_W-1:0] fxp_t;

    typedef struct packed {
        fxp_t angle;
        fxp_t cos;
    } cos_result_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_FINISH
    } seq_state_t;

endpackage

// File: rtl/cos_sweep_sequencer_if.sv
// rtl/cos_sweep_sequencer_if.sv - engine request and result stream signals
// Purpose: bundles the engine start/ready handshake and the result stream.
// Ports (master = sequencer side):
//   eng_start/eng_angle  out  request pulse and angle to the cosine engine
//   eng_ready/eng_cos    in   engine completion level and result
//   res_valid/res_angle/res_cos  out  result FIFO head
//   res_ready            in   consumer accept
interface cos_sweep_sequencer_if;
    import taylor_pkg::*;

    logic eng_start;
    fxp_t eng_angle;
    logic eng_ready;
    fxp_t eng_cos;

    logic res_valid;
    logic res_ready;
    fxp_t res_angle;
    fxp_t res_cos;

    modport master (
        output eng_start, eng_angle, res_valid, res_angle, res_cos,
        input  eng_ready, eng_cos, res_ready
    );

    modport slave (
        input  eng_start, eng_angle, res_valid, res_angle, res_cos,
        output eng_ready, eng_cos, res_ready
    );

endinterface

// File: rtl/sweep_result_fifo.sv
// rtl/sweep_result_fifo.sv - synchronous FIFO of (angle, cos) results
// Purpose: small result buffer; push and pop in the same cycle are both honoured.
// Ports:
//   clock, reset      in   clock, asynchronous active-high reset (flushes)
//   push, push_data   in   write request and record
//   pop               in   read request (ignored when empty)
//   pop_data          out  head record (zero after reset)
//   full, empty       out  occupancy flags
module sweep_result_fifo
    import taylor_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        push,
    input  cos_result_t push_data,
    input  logic        pop,
    output cos_result_t pop_data,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

    cos_result_t   mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == DEPTH_C);
    assign do_pop  = pop && !empty;
    // A full FIFO still takes a push when the head leaves in the same cycle.
    assign do_push = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/cos_sweep_sequencer.sv
// rtl/cos_sweep_sequencer.sv - drives a programmed angle sweep through the cosine engine
// Purpose: issues one engine request at a time, captures each result and
//          streams (angle, cos) pairs out through a small result FIFO.
// Ports:
//   clock, reset     in   clock, asynchronous active-high reset
//   sweep_start      in   start pulse, accepted only when idle
//   angle_first/angle_step/point_count  in  sweep program, sampled on accept
//   busy/done/error  out  sweep status (error is a sticky timeout flag)
//   bus              master side of engine handshake and result stream
module cos_sweep_sequencer
    import taylor_pkg::*;
#(
    parameter int CNT_W          = 10,
    parameter int FIFO_DEPTH     = 4,
    parameter int TIMEOUT_CYCLES = 4096
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  sweep_start,
    input  fxp_t                  angle_first,
    input  fxp_t                  angle_step,
    input  logic [CNT_W-1:0]      point_count,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    cos_sweep_sequencer_if.master bus
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    seq_state_t       state;
    fxp_t             angle;
    fxp_t             step;
    logic [CNT_W-1:0] remaining;
    logic [TW-1:0]    tmo_cnt;
    logic             eng_ready_q;
    logic             eng_start_r;
    fxp_t             eng_angle_r;

    logic             eng_rise;
    logic             push;
    cos_result_t      push_data;
    cos_result_t      head;
    logic             fifo_full;
    logic             fifo_empty;

    // Only a fresh rise counts, so a level left high by the previous
    // request cannot complete the current one.
    assign eng_rise = bus.eng_ready && !eng_ready_q;

    // eng_cos is valid one cycle after the rise, which is the CAPTURE cycle.
    assign push            = (state == S_CAPTURE);
    assign push_data.angle = eng_angle_r;
    assign push_data.cos   = bus.eng_cos;

    assign bus.eng_start = eng_start_r;
    assign bus.eng_angle = eng_angle_r;
    assign bus.res_valid = !fifo_empty;
    assign bus.res_angle = head.angle;
    assign bus.res_cos   = head.cos;

    sweep_result_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (bus.res_ready),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_IDLE;
            angle       <= '0;
            step        <= '0;
            remaining   <= '0;
            tmo_cnt     <= '0;
            eng_ready_q <= 1'b0;
            eng_start_r <= 1'b0;
            eng_angle_r <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            error       <= 1'b0;
        end else begin
            eng_ready_q <= bus.eng_ready;
            eng_start_r <= 1'b0;
            done        <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (sweep_start) begin
                        angle     <= angle_first;
                        step      <= angle_step;
                        remaining <= point_count;
                        error     <= 1'b0;
                        busy      <= 1'b1;
                        state     <= (point_count == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    // Issuing only with a free slot guarantees the later push fits.
                    if (!fifo_full) begin
                        eng_start_r <= 1'b1;
                        eng_angle_r <= angle;
                        tmo_cnt     <= '0;
                        state       <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_rise) begin
                        state <= S_CAPTURE;
                    end else if (tmo_cnt == TMO_LAST) begin
                        error <= 1'b1;
                        state <= S_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_CAPTURE: begin
                    angle     <= angle + step;
                    remaining <= remaining - 1'b1;
                    state     <= (remaining == CNT_W'(1)) ? S_FINISH : S_ISSUE;
                end
                S_FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_cos_sweep_sequencer.sv
// tb/tb_cos_sweep_sequencer.sv - self-checking bench for cos_sweep_sequencer
module tb_cos_sweep_sequencer;
    import taylor_pkg::*;

    typedef struct {
        logic [23:0] first;
        logic [23:0] step;
        int          cnt;
        bit          hang;
        int          mode;
        bit          exp_err;
        int          exp_starts;
    } vec_t;

    logic       clock = 1'b0;
    logic       rst = 1'b0;
    logic       sweep_start = 1'b0;
    fxp_t       angle_first = '0;
    fxp_t       angle_step = '0;
    logic [9:0] point_count = '0;
    logic       busy;
    logic       done;
    logic       error;

    cos_sweep_sequencer_if bus ();

    cos_sweep_sequencer #(
        .CNT_W          (10),
        .FIFO_DEPTH     (4),
        .TIMEOUT_CYCLES (64)
    ) dut (
        .clock       (clock),
        .reset       (rst),
        .sweep_start (sweep_start),
        .angle_first (angle_first),
        .angle_step  (angle_step),
        .point_count (point_count),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .bus         (bus)
    );

    always #5 clock = ~clock;

    int          n_vec = 0;
    int          n_err = 0;
    logic [47:0] got[$];
    logic [23:0] starts_q[$];
    bit          eng_hang = 1'b0;
    int          res_mode = 2;
    bit          saw_done;
    bit          err_at_done;
    vec_t        vecs[6];

    function automatic logic [23:0] ref_cos(input logic [23:0] a);
        int  ai;
        int  v;
        real r;
        ai = $signed(a);
        r  = $itor(ai) / 1024.0;
        v  = $rtoi($floor($cos(r) * 1024.0 + 0.5));
        return v[23:0];
    endfunction

    task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Engine: rises eng_ready 20 cycles after eng_start; eng_cos is garbage at
    // the rise and valid from the following cycle; ready drops on the next start.
    int          eng_cnt = 0;
    bit          cos_pend = 1'b0;
    logic [23:0] eng_a = '0;
    always @(negedge clock) begin
        if (rst) begin
            bus.eng_ready = 1'b0;
            bus.eng_cos   = '0;
            eng_cnt       = 0;
            cos_pend      = 1'b0;
        end else begin
            if (cos_pend) begin
                bus.eng_cos = ref_cos(eng_a);
                cos_pend    = 1'b0;
            end
            if (bus.eng_start) begin
                eng_a         = bus.eng_angle;
                bus.eng_ready = 1'b0;
                eng_cnt       = eng_hang ? 0 : 20;
            end else if (eng_cnt > 0) begin
                eng_cnt--;
                if (eng_cnt == 0) begin
                    bus.eng_ready = 1'b1;
                    bus.eng_cos   = 24'h5A5A5A;
                    cos_pend      = 1'b1;
                end
            end
        end
    end

    // Consumer: 0 = always ready, 1 = random, otherwise held off.
    always @(posedge clock) begin
        #1;
        case (res_mode)
            0:       bus.res_ready = 1'b1;
            1:       bus.res_ready = 1'($urandom_range(0, 1));
            default: bus.res_ready = 1'b0;
        endcase
    end

    always @(negedge clock) begin
        if (!rst) begin
            if (bus.res_valid && bus.res_ready) got.push_back({bus.res_angle, bus.res_cos});
            if (bus.eng_start) starts_q.push_back(bus.eng_angle);
        end
    end

    task automatic pulse_start(input logic [23:0] first, input logic [23:0] step, input int cnt);
        @(posedge clock); #1;
        angle_first = first;
        angle_step  = step;
        point_count = 10'(cnt);
        sweep_start = 1'b1;
        @(posedge clock); #1;
        sweep_start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        saw_done = 1'b0;
        for (int k = 0; k < 5000; k++) begin
            @(negedge clock);
            if (done) begin
                saw_done    = 1'b1;
                err_at_done = error;
                chk({name, "_busy_at_done"}, busy, 0);
                break;
            end
        end
        chk({name, "_done_seen"}, saw_done, 1);
    endtask

    task automatic drain();
        res_mode = 0;
        repeat (12) @(negedge clock);
        chk("drained_res_valid", bus.res_valid, 0);
    endtask

    task automatic wait_starts(input int n, input string name);
        bit reached = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            @(negedge clock);
            if (starts_q.size() >= n) begin
                reached = 1'b1;
                break;
            end
        end
        chk(name, reached, 1);
    endtask

    task automatic run_sweep(input logic [23:0] first, input logic [23:0] step, input int cnt,
                             input bit hang, input int mode);
        got.delete();
        starts_q.delete();
        eng_hang = hang;
        res_mode = mode;
        pulse_start(first, step, cnt);
        chk("busy_after_start", busy, 1);
        chk("error_cleared", error, 0);
        wait_done("sweep");
        drain();
    endtask

    // Expected stream: point i is at first + i*step (mod 2^24) with its cosine.
    task automatic check_results(input logic [23:0] first, input logic [23:0] step, input int n);
        logic [23:0] ea;
        logic [23:0] ec;
        chk("res_count", got.size(), n);
        for (int i = 0; i < n && i < got.size(); i++) begin
            ea = first + 24'(i) * step;
            ec = ref_cos(ea);
            chk($sformatf("res_angle[%0d]", i), got[i][47:24], ea);
            chk($sformatf("res_cos[%0d]", i), got[i][23:0], ec);
        end
    endtask

    initial begin
        logic [23:0] exp_c[4];
        logic [23:0] rf;
        logic [23:0] rs;
        int          rc;

        vecs[0] = '{24'd0,      24'd0,      0, 1'b0, 0, 1'b0, 0};
        vecs[1] = '{24'd100,    24'd7,      3, 1'b1, 0, 1'b1, 1};
        vecs[2] = '{24'hFFF800, 24'h000300, 5, 1'b0, 1, 1'b0, 5};
        vecs[3] = '{24'h7FFF00, 24'h000200, 3, 1'b0, 0, 1'b0, 3};
        vecs[4] = '{24'h123456, 24'hFFFF00, 6, 1'b0, 1, 1'b0, 6};
        vecs[5] = '{24'd3000,   24'd0,      1, 1'b0, 0, 1'b0, 1};
        exp_c   = '{24'd1024, 24'd992, 24'd899, 24'd749};

        #1 rst = 1'b1;
        #2;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_error", error, 0);
        chk("rst_eng_start", bus.eng_start, 0);
        chk("rst_eng_angle", $unsigned(bus.eng_angle), 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_angle", $unsigned(bus.res_angle), 0);
        chk("rst_res_cos", $unsigned(bus.res_cos), 0);
        repeat (3) @(posedge clock);
        @(negedge clock) rst = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_sweep(vecs[i].first, vecs[i].step, vecs[i].cnt, vecs[i].hang, vecs[i].mode);
            chk($sformatf("vec%0d_error", i), err_at_done, vecs[i].exp_err);
            chk($sformatf("vec%0d_error_sticky", i), error, vecs[i].exp_err);
            chk($sformatf("vec%0d_starts", i), starts_q.size(), vecs[i].exp_starts);
            check_results(vecs[i].first, vecs[i].step, vecs[i].hang ? 0 : vecs[i].cnt);
        end

        // Single point at 1.5 rad.
        run_sweep(24'd1536, 24'd0, 1, 1'b0, 0);
        chk("single_starts", starts_q.size(), 1);
        if (starts_q.size() > 0) chk("single_eng_angle", starts_q[0], 24'd1536);
        chk("single_count", got.size(), 1);
        if (got.size() > 0) chk("single_pair", got[0], {24'd1536, 24'd72});
        chk("single_error", err_at_done, 0);

        // Four-point sweep with known results.
        run_sweep(24'd0, 24'd256, 4, 1'b0, 0);
        chk("sweep4_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            chk($sformatf("sweep4_pair[%0d]", i), got[i], {24'(i * 256), exp_c[i]});
        end

        // Angle wrap past the positive limit.
        run_sweep(24'h7FFF00, 24'h000200, 2, 1'b0, 0);
        if (starts_q.size() > 1) chk("wrap_2nd_angle", starts_q[1], 24'h800100);
        chk("wrap_starts", starts_q.size(), 2);

        // Backpressure: FIFO fills, issue stalls, a start while busy is ignored.
        got.delete();
        starts_q.delete();
        eng_hang = 1'b0;
        res_mode = 2;
        pulse_start(24'd100, 24'd50, 8);
        wait_starts(4, "bp_reach4");
        repeat (60) @(negedge clock);
        chk("bp_starts_stalled", starts_q.size(), 4);
        chk("bp_busy", busy, 1);
        chk("bp_res_valid", bus.res_valid, 1);
        pulse_start(24'd0, 24'd0, 1);
        res_mode = 0;
        wait_done("bp");
        drain();
        chk("bp_starts_total", starts_q.size(), 8);
        check_results(24'd100, 24'd50, 8);

        // Reset while waiting on the second point.
        got.delete();
        starts_q.delete();
        res_mode = 2;
        pulse_start(24'd0, 24'd256, 3);
        wait_starts(2, "rst_reach2");
        repeat (5) @(negedge clock);
        chk("rst_pre_fifo", bus.res_valid, 1);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_eng_start", bus.eng_start, 0);
        chk("mid_rst_eng_angle", $unsigned(bus.eng_angle), 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        chk("mid_rst_res_cos", $unsigned(bus.res_cos), 0);
        repeat (2) @(negedge clock);
        rst = 1'b0;
        run_sweep(24'h000400, 24'h000100, 3, 1'b0, 0);
        chk("post_rst_starts", starts_q.size(), 3);
        check_results(24'h000400, 24'h000100, 3);

        // Randomised sweeps with random consumer backpressure.
        for (int r = 0; r < 6; r++) begin
            rf = 24'($urandom);
            rs = 24'($urandom);
            rc = $urandom_range(1, 10);
            run_sweep(rf, rs, rc, 1'b0, 1);
            chk($sformatf("rnd%0d_error", r), err_at_done, 0);
            chk($sformatf("rnd%0d_starts", r), starts_q.size(), rc);
            check_results(rf, rs, rc);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
